// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmit and receive sides).
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: one-cycle tick on the last cycle of every CLKS_PER_BIT period.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // With CLKS_PER_BIT=1 the counter sits at zero and tick is always high.
    assign tick = (cnt == LAST);
endmodule

// File: rtl/serial_block_tx.sv
// Framed LSB-first serial transmitter with a one-word holding buffer and a
// per-word completion pulse (sDone) for the upstream address counter.
module serial_block_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             sDone
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state, state_n;
    logic             buf_full, buf_full_n;
    logic [WIDTH-1:0] buf_data;
    logic [WIDTH-1:0] shift;
    logic             par_bit;
    logic [BW-1:0]    bit_idx;
    logic             tick;
    logic             load;
    logic             accept;

    assign accept     = data_valid && data_ready;
    assign buf_full_n = accept || (buf_full && !load);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    load    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick && bit_idx == LAST_BIT)
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                // A buffered word reloads straight into START: no idle gap.
                if (tick) begin
                    if (buf_full) begin
                        load    = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        serial_out = LINE_IDLE;
        case (state)
            START:   serial_out = START_LVL;
            DATA:    serial_out = shift[0];
            PARITY:  serial_out = par_bit;
            default: serial_out = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            bit_idx    <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            sDone      <= 1'b0;
        end else begin
            state      <= state_n;
            buf_full   <= buf_full_n;
            data_ready <= !buf_full_n;
            // Registered status: stays high through the sDone cycle.
            busy       <= (state != IDLE) || buf_full;
            sDone      <= (state == STOP) && tick;
            if (accept)
                buf_data <= data_in;
            if (load) begin
                shift   <= buf_data;
                par_bit <= ^buf_data;
                bit_idx <= '0;
            end else if (state == DATA && tick) begin
                shift   <= shift >> 1;
                bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_block_tx.sv
// Bench for serial_block_tx: default config plus a CLKS_PER_BIT=1, no-parity instance.
module tb_serial_block_tx;
    localparam int N = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0, data_in2 = '0;
    logic       data_valid = 1'b0, data_valid2 = 1'b0;
    logic       data_ready, serial_out, busy, sDone;
    logic       data_ready2, serial_out2, busy2, sDone2;

    serial_block_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .serial_out(serial_out), .busy(busy), .sDone(sDone)
    );

    serial_block_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .clock(clock), .reset(reset), .data_in(data_in2), .data_valid(data_valid2),
        .data_ready(data_ready2), .serial_out(serial_out2), .busy(busy2), .sDone(sDone2)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Per-cycle trace; index k holds the value seen after the k-th posedge.
    bit line_at [N];
    bit done_at [N];
    bit rdy_at  [N];
    bit busy_at [N];
    bit line2_at[N];
    bit done2_at[N];

    always @(negedge clock) begin
        if (cyc < N) begin
            line_at[cyc]  = serial_out;
            done_at[cyc]  = sDone;
            rdy_at[cyc]   = data_ready;
            busy_at[cyc]  = busy;
            line2_at[cyc] = serial_out2;
            done2_at[cyc] = sDone2;
        end
    end

    int checks = 0;
    int errors = 0;

    typedef bit bq_t[$];

    // Reference frame: start, LSB-first data, optional even parity, stop.
    function automatic bq_t frame_bits(input logic [7:0] w, input int cpb, input bit par);
        bq_t q;
        int ones = 0;
        for (int c = 0; c < cpb; c++) q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            ones += int'(w[i]);
            for (int c = 0; c < cpb; c++) q.push_back(w[i]);
        end
        if (par) for (int c = 0; c < cpb; c++) q.push_back(bit'(ones % 2));
        for (int c = 0; c < cpb; c++) q.push_back(1'b1);
        return q;
    endfunction

    logic [7:0] rx_words[$];
    int         rx_ferr;

    // Mid-bit sampling receiver over the recorded line of the default instance.
    task automatic rx_decode(input int from, input int to);
        int i = from;
        rx_words.delete();
        rx_ferr = 0;
        while (i < to) begin
            if (line_at[i] == 1'b0) begin
                logic [7:0] w = '0;
                int ones = 0;
                for (int k = 0; k < 8; k++) begin
                    w[k] = line_at[i + 4 * (k + 1) + 2];
                    ones += int'(w[k]);
                end
                if (line_at[i + 4 * 9 + 2] != bit'(ones % 2)) rx_ferr++;
                if (line_at[i + 4 * 10 + 2] != 1'b1) rx_ferr++;
                rx_words.push_back(w);
                i += 44;
            end else begin
                i++;
            end
        end
    endtask

    task automatic send(input logic [7:0] w, output int acc);
        int n = 0;
        data_in = w;
        data_valid = 1'b1;
        while (!data_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!data_ready) begin
            errors++;
            $display("FAIL send_timeout: data_ready=%0b after %0d cycles, required 1", data_ready, n);
        end
        acc = cyc + 1;
        @(negedge clock);
        data_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] w, output int acc);
        int n = 0;
        data_in2 = w;
        data_valid2 = 1'b1;
        while (!data_ready2 && n < 400) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!data_ready2) begin
            errors++;
            $display("FAIL send2_timeout: data_ready=%0b after %0d cycles, required 1", data_ready2, n);
        end
        acc = cyc + 1;
        @(negedge clock);
        data_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks += 4;
        if (serial_out !== 1'b1) begin errors++; $display("FAIL rst_line: got %b want 1", serial_out); end
        if (sDone !== 1'b0) begin errors++; $display("FAIL rst_sdone: got %b want 0", sDone); end
        if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", data_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", data_ready); end
    endtask

    task automatic test_single();
        int acc, s, bad = 0, nd = 0, n = 0;
        bq_t exp;
        send(8'hA5, acc);
        s = acc + 1;
        while (!sDone && n < 200) begin @(negedge clock); n++; end
        repeat (20) @(negedge clock);
        exp = frame_bits(8'hA5, 4, 1'b1);
        foreach (exp[i]) if (line_at[s + i] != exp[i]) bad++;
        for (int i = s - 2; i <= s + 60; i++) nd += int'(done_at[i]);
        checks += 7;
        if (line_at[s - 1] !== 1'b1) begin errors++; $display("FAIL a5_latency: line before start %b want 1", line_at[s - 1]); end
        if (bad != 0) begin errors++; $display("FAIL a5_frame: %0d bit cycles wrong, want 0", bad); end
        if (line_at[s + 44] !== 1'b1) begin errors++; $display("FAIL a5_idle_after: got %b want 1", line_at[s + 44]); end
        if (done_at[s + 44] !== 1'b1) begin errors++; $display("FAIL a5_sdone_pos: got %b want 1", done_at[s + 44]); end
        if (nd != 1) begin errors++; $display("FAIL a5_sdone_count: got %0d want 1", nd); end
        if (busy_at[s + 44] !== 1'b1) begin errors++; $display("FAIL a5_busy_at_done: got %b want 1", busy_at[s + 44]); end
        if (busy_at[s + 45] !== 1'b0) begin errors++; $display("FAIL a5_busy_fall: got %b want 0", busy_at[s + 45]); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3, s1, bad = 0, nd = 0;
        bq_t exp, f;
        send(8'h01, a1);
        s1 = a1 + 1;
        repeat (6) @(negedge clock);
        send(8'hFF, a2);
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", data_ready); end
        send(8'h5A, a3);
        while (cyc < s1 + 140) @(negedge clock);
        f = frame_bits(8'h01, 4, 1'b1); foreach (f[i]) exp.push_back(f[i]);
        f = frame_bits(8'hFF, 4, 1'b1); foreach (f[i]) exp.push_back(f[i]);
        f = frame_bits(8'h5A, 4, 1'b1); foreach (f[i]) exp.push_back(f[i]);
        foreach (exp[i]) if (line_at[s1 + i] != exp[i]) bad++;
        for (int i = s1; i <= s1 + 138; i++) nd += int'(done_at[i]);
        checks += 9;
        if (bad != 0) begin errors++; $display("FAIL b2b_frames: %0d bit cycles wrong, want 0", bad); end
        if (line_at[s1 + 36] !== 1'b1) begin errors++; $display("FAIL b2b_parity1: got %b want 1", line_at[s1 + 36]); end
        if (line_at[s1 + 80] !== 1'b0) begin errors++; $display("FAIL b2b_parity2: got %b want 0", line_at[s1 + 80]); end
        if (rdy_at[s1 + 43] !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold: got %b want 0", rdy_at[s1 + 43]); end
        if (a3 != s1 + 45) begin errors++; $display("FAIL b2b_third_accept: cycle %0d want %0d", a3, s1 + 45); end
        if (done_at[s1 + 44] !== 1'b1) begin errors++; $display("FAIL b2b_sdone1: got %b want 1", done_at[s1 + 44]); end
        if (done_at[s1 + 88] !== 1'b1) begin errors++; $display("FAIL b2b_sdone2: got %b want 1", done_at[s1 + 88]); end
        if (done_at[s1 + 132] !== 1'b1) begin errors++; $display("FAIL b2b_sdone3: got %b want 1", done_at[s1 + 132]); end
        if (nd != 3) begin errors++; $display("FAIL b2b_sdone_count: got %0d want 3", nd); end
    endtask

    task automatic test_reset_abort();
        int acc, s, nd = 0, bad = 0, n = 0;
        bq_t exp;
        send(8'h3C, acc);
        s = acc + 1;
        while (cyc < s + 9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks += 3;
        if (serial_out !== 1'b1) begin errors++; $display("FAIL abort_line: got %b want 1", serial_out); end
        if (sDone !== 1'b0) begin errors++; $display("FAIL abort_sdone: got %b want 0", sDone); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(negedge clock);
        checks += 2;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", data_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_buf_empty: busy %b want 0", busy); end
        repeat (60) begin
            nd += int'(sDone);
            @(negedge clock);
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL abort_no_sdone: got %0d pulses want 0", nd); end
        send(8'h3C, acc);
        s = acc + 1;
        while (!sDone && n < 200) begin @(negedge clock); n++; end
        repeat (4) @(negedge clock);
        exp = frame_bits(8'h3C, 4, 1'b1);
        foreach (exp[i]) if (line_at[s + i] != exp[i]) bad++;
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL abort_resend_frame: %0d bit cycles wrong, want 0", bad); end
        if (done_at[s + 44] !== 1'b1) begin errors++; $display("FAIL abort_resend_sdone: got %b want 1", done_at[s + 44]); end
    endtask

    task automatic test_fast_noparity();
        int acc, s, bad = 0, nd = 0;
        bq_t exp;
        send2(8'h80, acc);
        s = acc + 1;
        repeat (20) @(negedge clock);
        exp = frame_bits(8'h80, 1, 1'b0);
        foreach (exp[i]) if (line2_at[s + i] != exp[i]) bad++;
        for (int i = s; i <= s + 15; i++) nd += int'(done2_at[i]);
        checks += 4;
        if (line2_at[s - 1] !== 1'b1) begin errors++; $display("FAIL cpb1_latency: got %b want 1", line2_at[s - 1]); end
        if (bad != 0) begin errors++; $display("FAIL cpb1_frame: %0d bit cycles wrong, want 0", bad); end
        if (done2_at[s + 10] !== 1'b1) begin errors++; $display("FAIL cpb1_sdone_pos: got %b want 1", done2_at[s + 10]); end
        if (nd != 1) begin errors++; $display("FAIL cpb1_sdone_count: got %0d want 1", nd); end
    endtask

    // Sends a list of words with random offer gaps; sDone drives an address counter model.
    task automatic run_stream(input logic [7:0] words[$], input int max_gap, input string tag);
        int from, acc, n = 0, bad = 0;
        logic [15:0] addr = '0;
        from = cyc;
        foreach (words[i]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clock);
            send(words[i], acc);
        end
        while (busy && n < 3000) begin @(negedge clock); n++; end
        repeat (10) @(negedge clock);
        for (int i = from; i < cyc; i++) if (done_at[i]) addr++;
        rx_decode(from, cyc - 1);
        if (rx_words.size() == words.size())
            foreach (words[i]) if (rx_words[i] !== words[i]) bad++;
        checks += 4;
        if (int'(addr) != words.size()) begin errors++; $display("FAIL %s_addr: got %0d want %0d", tag, addr, words.size()); end
        if (rx_words.size() != words.size()) begin errors++; $display("FAIL %s_rx_count: got %0d want %0d", tag, rx_words.size(), words.size()); end
        if (bad != 0) begin errors++; $display("FAIL %s_rx_data: %0d words wrong, want 0", tag, bad); end
        if (rx_ferr != 0) begin errors++; $display("FAIL %s_rx_framing: %0d errors, want 0", tag, rx_ferr); end
    endtask

    task automatic test_address_stream();
        logic [7:0] w[$];
        for (int i = 0; i < 16; i++) w.push_back(8'(i));
        run_stream(w, 50, "addr16");
    endtask

    task automatic test_random_words();
        logic [7:0] w[$];
        for (int i = 0; i < 12; i++) w.push_back(8'($urandom));
        run_stream(w, 8, "rand");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_abort();
        test_fast_noparity();
        test_address_stream();
        test_random_words();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
